// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the six-digit display multiplexer.
//   SEG_BLANK  - segment bus value with every segment off (active-low)
//   AN_OFF     - anode vector with every digit off (active-low)
//   NUM_DIGITS - number of multiplexed digits
package disp_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] AN_OFF = 6'b111111;
  localparam int NUM_DIGITS = 6;
endpackage

// File: rtl/disp_mux6_slot_timer.sv
// slot_timer: per-slot cycle counter and digit index for the display scan.
//   clk, rst_n      - clock, asynchronous active-low reset
//   cnt_o [N-1:0]   - cycle position inside the current slot
//   idx_o [2:0]     - current digit index, 0..5
//   slot_last_o     - high on the final clock of a slot
//   frame_last_o    - high on the final clock of slot 5 (end of frame)
module slot_timer #(
  parameter int N = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] cnt_o,
  output logic [2:0]   idx_o,
  output logic         slot_last_o,
  output logic         frame_last_o
);
  logic [N-1:0] cnt_q;
  logic [2:0]   idx_q, idx_d;
  assign cnt_o        = cnt_q;
  assign idx_o        = idx_q;
  assign slot_last_o  = &cnt_q;
  assign frame_last_o = slot_last_o && idx_q == 3'd5;
  // Indices 6 and 7 are unreachable; recover to 0 immediately if ever seen.
  always_comb
    idx_d = idx_q > 3'd5 ? 3'd0 :
            slot_last_o  ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      idx_q <= idx_d;
    end
endmodule

// File: rtl/disp_mux6.sv
// disp_mux6: six-digit time-multiplexed seven-segment driver with
// frame-synchronous snapshot, dead-time blanking, brightness and enables.
//   clk, rst_n     - clock, asynchronous active-low reset
//   in0..in5 [7:0] - active-low segment patterns, in0 = rightmost digit
//   en             - global display enable
//   dig_en [5:0]   - per-digit enable mask
//   bri [3:0]      - brightness, 0 = off, 15 = max
//   an [5:0]       - active-low anodes (registered)
//   sseg [7:0]     - active-low segment bus (registered)
//   frame_tick     - one-clock pulse on the snapshot clock (registered)
module disp_mux6 import disp_pkg::*; #(
  parameter int N     = 18,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic       en,
  input  logic [5:0] dig_en,
  input  logic [3:0] bri,
  output logic [5:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);
  localparam logic [N-1:0] BLANK_C = N'(BLANK);
  logic [N-1:0] cnt;
  logic [2:0]   idx;
  logic         slot_last, frame_last, lit;
  logic [7:0]   in_w [NUM_DIGITS];
  logic [7:0]   sh_q [NUM_DIGITS];
  logic [7:0]   dig_en_w;
  logic [3:0]   bri_q;
  logic [5:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic         tick_q;
  slot_timer #(.N(N)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_o       (cnt),
    .idx_o       (idx),
    .slot_last_o (slot_last),
    .frame_last_o(frame_last)
  );
  assign in_w       = '{in0, in1, in2, in3, in4, in5};
  // Padding makes the enable lookup safe (dark) for the unreachable indices.
  assign dig_en_w   = {2'b00, dig_en};
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;
  // PWM: the top four slot-counter bits act as a coarse ramp against bri_q.
  assign lit = en && dig_en_w[idx] && cnt >= BLANK_C && bri_q != 4'd0 &&
               cnt[N-1:N-4] <= bri_q;
  always_comb begin
    an_d   = lit ? ~(6'b000001 << idx) : AN_OFF;
    sseg_d = lit ? sh_q[idx] : SEG_BLANK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q   <= '{default: SEG_BLANK};
      bri_q  <= '0;
      an_q   <= AN_OFF;
      sseg_q <= SEG_BLANK;
      tick_q <= 1'b0;
    end else begin
      if (frame_last) sh_q <= in_w;
      if (slot_last) bri_q <= bri;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      tick_q <= frame_last;
    end
endmodule

// File: tb/tb_disp_mux6.sv
// tb_disp_mux6: scoreboard plus directed checks for disp_mux6 at N=5, BLANK=4.
module tb_disp_mux6;
  localparam int N = 5;
  localparam int BLANK = 4;
  localparam int SLOT = 32;
  typedef struct {
    logic [5:0] an;
    logic [7:0] sseg;
    logic       tick;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in0 = 8'hC0, in1 = 8'hF9, in2 = 8'hA4, in3 = 8'hB0, in4 = 8'h99, in5 = 8'h92;
  logic       en = 1'b1;
  logic [5:0] dig_en = 6'h3F;
  logic [3:0] bri = 4'd0;
  logic [5:0] an;
  logic [7:0] sseg;
  logic       frame_tick;
  int         n_chk = 0, n_pass = 0, n_fail = 0;
  exp_t       q[$];
  int         m_cnt = 0, m_idx = 0, m_bri = 0;
  logic [7:0] m_sh [6] = '{default: 8'hFF};
  int         k;
  int         first;
  disp_mux6 #(.N(N), .BLANK(BLANK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .en        (en),
    .dig_en    (dig_en),
    .bri       (bri),
    .an        (an),
    .sseg      (sseg),
    .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference model: each clock it pushes the output the DUT must show one cycle later.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0;
      m_idx = 0;
      m_bri = 0;
      m_sh  = '{default: 8'hFF};
      q.delete();
    end else begin
      exp_t e;
      bit lit;
      lit = en && dig_en[m_idx] && m_cnt >= BLANK && m_bri != 0 && (m_cnt >> (N - 4)) <= m_bri;
      e.an   = lit ? 6'(~(6'b1 << m_idx)) : 6'h3F;
      e.sseg = lit ? m_sh[m_idx] : 8'hFF;
      e.tick = m_cnt == SLOT - 1 && m_idx == 5;
      q.push_back(e);
      if (m_cnt == SLOT - 1) begin
        if (m_idx == 5) m_sh = '{in0, in1, in2, in3, in4, in5};
        m_bri = int'(bri);
        m_idx = (m_idx + 1) % 6;
      end
      m_cnt = (m_cnt + 1) % SLOT;
    end
  end
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_an", 32'(an), 32'(e.an));
      chk("sb_sseg", 32'(sseg), 32'(e.sseg));
      chk("sb_tick", 32'(frame_tick), 32'(e.tick));
    end else begin
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_sseg", 32'(sseg), 32'hFF);
      chk("rst_tick", 32'(frame_tick), 32'h0);
    end
    chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
  end
  task automatic go(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask
  // Runs the first frame after release with bri held at 0 until late in slot 5.
  task automatic first_frame(input string tag);
    first = -1;
    while (first < 0 && k < 400) begin
      @(negedge clk);
      k++;
      if (frame_tick === 1'b1) first = k;
      if (k == 180) bri = 4'd15;
    end
    chk(tag, 32'(first), 32'd192);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    first_frame("first_tick");
    go(196); chk("f2_s0_dead", 32'(an), 32'h3F);
    go(197); chk("f2_s0_an", 32'(an), 32'h3E); chk("f2_s0_seg", 32'(sseg), 32'hC0);
    go(229); chk("f2_s1_an", 32'(an), 32'h3D); chk("f2_s1_seg", 32'(sseg), 32'hF9);
    go(240); in2 = 8'h88;
    go(265); chk("f2_s2_an", 32'(an), 32'h3B); chk("f2_s2_old", 32'(sseg), 32'hA4);
    go(383); chk("tick_pre", 32'(frame_tick), 32'h0);
    go(384); chk("tick_2nd", 32'(frame_tick), 32'h1);
    go(453); chk("f3_s2_an", 32'(an), 32'h3B); chk("f3_s2_new", 32'(sseg), 32'h88);
    go(490); bri = 4'd3;
    go(500); chk("s3_unchanged", 32'(an), 32'h37); chk("s3_seg", 32'(sseg), 32'hB0);
    go(516); chk("s4_dead", 32'(an), 32'h3F);
    go(517); chk("s4_lit_lo", 32'(an), 32'h2F); chk("s4_seg", 32'(sseg), 32'h99);
    go(520); chk("s4_lit_hi", 32'(an), 32'h2F);
    go(521); chk("s4_pwm_off", 32'(an), 32'h3F); chk("s4_pwm_seg", 32'(sseg), 32'hFF);
    go(530); bri = 4'd0;
    go(560); chk("bri0_dark", 32'(an), 32'h3F);
    go(570); bri = 4'd15; dig_en = 6'h3E;
    go(590); chk("digen_off", 32'(an), 32'h3F);
    go(620); chk("digen_s1_an", 32'(an), 32'h3D); chk("digen_s1_seg", 32'(sseg), 32'hF9);
    go(625); dig_en = 6'h3F;
    go(630); chk("en_before", 32'(an), 32'h3D); en = 1'b0;
    go(631); chk("en_off_an", 32'(an), 32'h3F); chk("en_off_seg", 32'(sseg), 32'hFF);
    go(635); en = 1'b1;
    go(636); chk("en_resume", 32'(an), 32'h3D);
    go(700); chk("pre_rst_an", 32'(an), 32'h37); chk("pre_rst_seg", 32'(sseg), 32'hB0);
    #2 rst_n = 1'b0; bri = 4'd0;
    #1 chk("async_an", 32'(an), 32'h3F); chk("async_seg", 32'(sseg), 32'hFF);
    chk("async_tick", 32'(frame_tick), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    first_frame("rst2_first_tick");
    go(197); chk("rst2_an", 32'(an), 32'h3E); chk("rst2_seg", 32'(sseg), 32'hC0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
